muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_unit.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: operand, control and result bundle between the MIPS
// datapath/control unit (master) and the multiply/divide unit (slave).
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       md_op;
  logic [WIDTH-1:0] busA;
  logic [WIDTH-1:0] busB;
  logic             hi_wr;
  logic             lo_wr;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, md_op, busA, busB, hi_wr, lo_wr,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, md_op, busA, busB, hi_wr, lo_wr,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit holding the MIPS HI/LO pair.
// Signed operations run on operand magnitudes and fix the signs in a final
// FIX cycle. mthi/mtlo writes are accepted only while idle.
// Optional build macro MULDIV_FAST_MULT_EN: mult/multu use a combinational
// multiply and go straight from IDLE to FIX; division stays iterative.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  state_t             nextState;
  logic               launch;

  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] accNext;
  logic [WIDTH-1:0]   opShift;
  logic [WIDTH-1:0]   shiftNext;
  logic [WIDTH-1:0]   aMag;
  logic [WIDTH-1:0]   bMag;
  logic               isDiv;
  logic               signA;
  logic               signB;

  logic [WIDTH-1:0]   hiReg;
  logic [WIDTH-1:0]   loReg;
  logic               doneReg;

  logic [WIDTH-1:0]   hiRes;
  logic [WIDTH-1:0]   loRes;
  logic [2*WIDTH-1:0] prodMag;
  logic [2*WIDTH-1:0] prodSigned;
  logic [WIDTH:0]     multSum;
  logic [WIDTH:0]     remShift;
  logic               remFits;
  logic               inSignA;
  logic               inSignB;

  // Two's-complement negate when neg is set (magnitude/sign conversion).
  function automatic logic [WIDTH-1:0] condNeg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] condNegWide(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign inSignA = ~bus.md_op[0] & bus.busA[WIDTH-1];
  assign inSignB = ~bus.md_op[0] & bus.busB[WIDTH-1];

  assign bus.busy = (state != IDLE);
  assign bus.done = doneReg;
  assign bus.hi   = hiReg;
  assign bus.lo   = loReg;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state logic: launch only from IDLE, RUN for WIDTH iterations, one FIX cycle.
  always_comb begin
    nextState = state;
    launch    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          launch = 1'b1;
`ifdef MULDIV_FAST_MULT_EN
          nextState = bus.md_op[1] ? RUN : FIX;
`else
          nextState = RUN;
`endif
        end
      end
      RUN: begin
        if (count == CW'(1)) nextState = FIX;
      end
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // One iteration: shift-add multiply (right-shifting product) or restoring divide.
  always_comb begin
    accNext   = acc;
    shiftNext = opShift;
    multSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (opShift[0] ? aMag : {WIDTH{1'b0}})};
    remShift  = {acc[2*WIDTH-1:WIDTH], opShift[WIDTH-1]};
    remFits   = (remShift >= {1'b0, bMag});
    if (isDiv) begin
      if (remFits) begin
        accNext   = {WIDTH'(remShift - {1'b0, bMag}), acc[WIDTH-1:0]};
        shiftNext = {opShift[WIDTH-2:0], 1'b1};
      end else begin
        accNext   = {remShift[WIDTH-1:0], acc[WIDTH-1:0]};
        shiftNext = {opShift[WIDTH-2:0], 1'b0};
      end
    end else begin
      accNext   = {multSum, acc[WIDTH-1:1]};
      shiftNext = opShift >> 1;
    end
  end

  // Final sign correction and the divide-by-zero special case.
  always_comb begin
    prodMag = acc;
`ifdef MULDIV_FAST_MULT_EN
    prodMag = {{WIDTH{1'b0}}, aMag} * {{WIDTH{1'b0}}, bMag};
`endif
    prodSigned = condNegWide(prodMag, signA ^ signB);
    hiRes      = prodSigned[2*WIDTH-1:WIDTH];
    loRes      = prodSigned[WIDTH-1:0];
    if (isDiv) begin
      if (bMag == '0) begin
        loRes = {WIDTH{1'b1}};
        hiRes = condNeg(aMag, signA);
      end else begin
        loRes = condNeg(opShift, signA ^ signB);
        hiRes = condNeg(acc[2*WIDTH-1:WIDTH], signA);
      end
    end
  end

  // Operand capture at launch and per-iteration multiplier/quotient shift.
  always_ff @(posedge clk) begin
    if (launch) begin
      isDiv   <= bus.md_op[1];
      signA   <= inSignA;
      signB   <= inSignB;
      aMag    <= condNeg(bus.busA, inSignA);
      bMag    <= condNeg(bus.busB, inSignB);
      opShift <= bus.md_op[1] ? condNeg(bus.busA, inSignA) : condNeg(bus.busB, inSignB);
    end else if (state == RUN) begin
      opShift <= shiftNext;
    end
  end

  // Counter, accumulator, HI/LO and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      acc     <= '0;
      hiReg   <= '0;
      loReg   <= '0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= (state == FIX);
      case (state)
        IDLE: begin
          if (launch) begin
            acc   <= '0;
            count <= CW'(WIDTH);
          end else begin
            if (bus.hi_wr) hiReg <= bus.busA;
            if (bus.lo_wr) loReg <= bus.busA;
          end
        end
        RUN: begin
          acc   <= accNext;
          count <= count - 1'b1;
        end
        FIX: begin
          hiReg <= hiRes;
          loReg <= loRes;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized scoreboard bench for muldiv_unit. Expected
// HI/LO pairs are queued at issue time and retired on each done pulse.
module tb_muldiv_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          applied     = 0;
  int          miscompares = 0;
  logic [63:0] expQ[$];
  logic [31:0] modelHi = '0;
  logic [31:0] modelLo = '0;
  logic        prevDone = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic, result packed as {HI, LO}.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p, qb, rb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin
        p = 64'(sa * sb);
        return p;
      end
      2'b01: begin
        p = {32'b0, a} * {32'b0, b};
        return p;
      end
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = sa / sb;
        r = sa % sb;
        qb = 64'(q);
        rb = 64'(r);
        return {rb[31:0], qb[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Monitor: retire one expectation per done pulse.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      check("done_has_expect", 64'(expQ.size() > 0), 64'd1);
      check("done_single", 64'(prevDone), 64'd0);
      if (expQ.size() > 0) check("result_hilo", {bus.hi, bus.lo}, expQ.pop_front());
    end
    prevDone <= bus.done;
  end

  // Issue one operation; caller is at a negedge, returns at the negedge after done.
  task automatic doOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit inject);
    logic [63:0] exp;
    int          busyCnt;
    int          lat;
    exp = model(op, a, b);
    expQ.push_back(exp);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.busA  = a;
    bus.busB  = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.busA  = $urandom;
    bus.busB  = $urandom;
    busyCnt   = 0;
    while (bus.busy && busyCnt < 100) begin
      busyCnt++;
      if (busyCnt == 1) check("hold_hilo_start", {bus.hi, bus.lo}, {modelHi, modelLo});
      if (busyCnt == 6) check("hold_hilo_run", {bus.hi, bus.lo}, {modelHi, modelLo});
      if (inject && busyCnt == 5) begin
        bus.start = 1'b1;
        bus.hi_wr = 1'b1;
        bus.lo_wr = 1'b1;
        bus.md_op = 2'b01;
        bus.busA  = 32'h0000DEAD;
      end else begin
        bus.start = 1'b0;
        bus.hi_wr = 1'b0;
        bus.lo_wr = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.hi_wr = 1'b0;
    bus.lo_wr = 1'b0;
`ifdef MULDIV_FAST_MULT_EN
    lat = op[1] ? 33 : 1;
`else
    lat = 33;
`endif
    check("busy_cycles", 64'(busyCnt), 64'(lat));
    check("done_after", 64'(bus.done), 64'd1);
    modelHi = exp[63:32];
    modelLo = exp[31:0];
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          mode;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.md_op = 2'b00;
    bus.busA  = '0;
    bus.busB  = '0;
    bus.hi_wr = 1'b0;
    bus.lo_wr = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset_busy_done", 64'({bus.busy, bus.done}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // mthi alone, then mthi+mtlo together
    bus.hi_wr = 1'b1;
    bus.busA  = 32'h00001234;
    @(negedge clk);
    bus.hi_wr = 1'b0;
    check("mthi", 64'(bus.hi), 64'h1234);
    bus.hi_wr = 1'b1;
    bus.lo_wr = 1'b1;
    bus.busA  = 32'hCAFE0001;
    @(negedge clk);
    bus.hi_wr = 1'b0;
    bus.lo_wr = 1'b0;
    check("mthi_mtlo", {bus.hi, bus.lo}, {32'hCAFE0001, 32'hCAFE0001});

    // asynchronous reset with no clock edge while asserted
    #2 reset = 1'b1;
    #1;
    check("async_reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("async_reset_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    reset   = 1'b0;
    modelHi = '0;
    modelLo = '0;

    // directed cases
    doOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    doOp(2'b00, 32'hFFFFFFF9, 32'd3, 1'b1);
    doOp(2'b10, 32'hFFFFFFF9, 32'd2, 1'b1);
    doOp(2'b11, 32'd100, 32'd0, 1'b0);
    doOp(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    doOp(2'b10, 32'hFFFFFF00, 32'd0, 1'b0);

    // start with mthi/mtlo in the same cycle: start wins
    bus.hi_wr = 1'b1;
    bus.lo_wr = 1'b1;
    doOp(2'b11, 32'd1000, 32'd7, 1'b0);

    // reset at E10 of a divide aborts it
    bus.start = 1'b1;
    bus.md_op = 2'b10;
    bus.busA  = $urandom;
    bus.busB  = $urandom | 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    check("abort_idle", 64'(bus.busy), 64'd0);
    @(negedge clk);
    reset   = 1'b0;
    modelHi = '0;
    modelLo = '0;
    doOp(2'b00, 32'd12345, 32'hFFFFFFFE, 1'b0);

    // randomized operations
    for (int i = 0; i < 24; i++) begin
      op   = 2'($urandom_range(0, 3));
      mode = $urandom_range(0, 3);
      case (mode)
        0: begin
          a = 32'($urandom_range(0, 40)) - 32'd20;
          b = 32'($urandom_range(0, 40)) - 32'd20;
        end
        1: begin
          a = $urandom;
          b = $urandom;
        end
        2: begin
          a = $urandom;
          b = 32'd0;
        end
        default: begin
          a = 32'h80000000;
          b = ($urandom_range(0, 1) == 0) ? 32'hFFFFFFFF : $urandom;
        end
      endcase
      doOp(op, a, b, (i % 4) == 0);
    end

    @(negedge clk);
    check("queue_drained", 64'(expQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
